// File: rtl/vga_scanout_if.sv
// Scanout port bundle: framebuffer read side plus VGA video outputs.
// The master drives the address and video; the slave returns read data.
interface vga_scanout_if;
  logic [18:0] fb_addr;
  logic [7:0]  fb_din;
  logic        hs;
  logic        vs;
  logic        de;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;
  logic        vblank;
  logic        frame_start;

  modport master (
    output fb_addr,
    output hs,
    output vs,
    output de,
    output r,
    output g,
    output b,
    output vblank,
    output frame_start,
    input  fb_din
  );

  modport slave (
    input  fb_addr,
    input  hs,
    input  vs,
    input  de,
    input  r,
    input  g,
    input  b,
    input  vblank,
    input  frame_start,
    output fb_din
  );
endinterface

// File: rtl/vga_scanout.sv
// VGA scanout: pixel-tick timing, framebuffer fetch one tick ahead,
// RGB332 -> 4:4:4 expansion with matching sync/enable pipeline.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4,
  parameter bit SYNC_POL = 1'b0
) (
  input logic clk,
  input logic rst,
  vga_scanout_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = $clog2(CLK_DIV);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  logic [DW-1:0] div;
  logic          tick;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  logic        act;
  logic        hs_on;
  logic        vs_on;
  logic        first;
  logic [18:0] addr;

  logic        act1;
  logic        hs1;
  logic        vs1;
  logic        first1;
  logic [18:0] fb_addr;

  logic       de;
  logic       hs;
  logic       vs;
  logic       frame_start;
  logic [3:0] r;
  logic [3:0] g;
  logic [3:0] b;

  assign tick = int'(div) == CLK_DIV - 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (tick) begin
      if (int'(hcnt) == H_TOTAL - 1) begin
        hcnt <= '0;
        if (int'(vcnt) == V_TOTAL - 1) begin
          vcnt <= '0;
        end else begin
          vcnt <= vcnt + 1'b1;
        end
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // Decode of the pixel the counters currently point at.
  always_comb begin
    act   = int'(hcnt) < H_ACTIVE && int'(vcnt) < V_ACTIVE;
    hs_on = int'(hcnt) >= H_ACTIVE + H_FP &&
            int'(hcnt) <  H_ACTIVE + H_FP + H_SYNC;
    vs_on = int'(vcnt) >= V_ACTIVE + V_FP &&
            int'(vcnt) <  V_ACTIVE + V_FP + V_SYNC;
    first = hcnt == '0 && vcnt == '0;
    addr  = '0;
    if (act) begin
      addr = 19'(vcnt) * 19'(H_ACTIVE) + 19'(hcnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act1    <= 1'b0;
      hs1     <= 1'b0;
      vs1     <= 1'b0;
      first1  <= 1'b0;
      fb_addr <= '0;
    end else if (tick) begin
      act1    <= act;
      hs1     <= hs_on;
      vs1     <= vs_on;
      first1  <= first;
      fb_addr <= addr;
    end
  end

  // RAM data has settled for CLK_DIV-1 clks by the next tick edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de <= 1'b0;
      hs <= ~SYNC_POL;
      vs <= ~SYNC_POL;
      r  <= '0;
      g  <= '0;
      b  <= '0;
    end else if (tick) begin
      de <= act1;
      hs <= hs1 ? SYNC_POL : ~SYNC_POL;
      vs <= vs1 ? SYNC_POL : ~SYNC_POL;
      if (act1) begin
        r <= {vga.fb_din[7:5], vga.fb_din[7]};
        g <= {vga.fb_din[4:2], vga.fb_din[4]};
        b <= {vga.fb_din[1:0], vga.fb_din[1:0]};
      end else begin
        r <= '0;
        g <= '0;
        b <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && act1 && first1;
    end
  end

  assign vga.fb_addr     = fb_addr;
  assign vga.hs          = hs;
  assign vga.vs          = vs;
  assign vga.de          = de;
  assign vga.r           = r;
  assign vga.g           = g;
  assign vga.b           = b;
  assign vga.frame_start = frame_start;
  assign vga.vblank      = int'(vcnt) >= V_ACTIVE;
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shrunken 24x10 raster (16x6 visible),
// with a CLK_DIV=4 unit and a CLK_DIV=2 unit sharing one RAM image.
module tb_vga_scanout;
  localparam int CD   = 4;
  localparam int HT   = 24;
  localparam int VT   = 10;
  localparam int FT   = HT * VT;
  localparam int NREC = 512;

  typedef struct {
    int h;
    int v;
    int addr;
    int de;
    int hs;
    int vs;
    int vb;
    int rgb;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_ff = 1'b0;
  logic bm = 1'b0;
  logic chk2 = 1'b0;

  always #5 clk = ~clk;

  vga_scanout_if vif();
  vga_scanout_if vif2();

  vga_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(CD), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga(vif)
  );

  vga_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(2), .SYNC_POL(1'b0)
  ) dut2 (
    .clk(clk),
    .rst(rst),
    .vga(vif2)
  );

  logic [7:0] ram [0:127];

  always @(posedge clk) begin
    vif.fb_din  <= force_ff ? 8'hFF :
                   (vif.fb_addr < 19'd128) ? ram[vif.fb_addr[6:0]] : 8'h00;
    vif2.fb_din <= force_ff ? 8'hFF :
                   (vif2.fb_addr < 19'd128) ? ram[vif2.fb_addr[6:0]] : 8'h00;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] conv(input logic [7:0] d);
    return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
  endfunction

  int ec;
  always @(posedge clk or posedge rst) begin
    if (rst) ec <= 0;
    else     ec <= ec + 1;
  end

  // Per-tick snapshot of the CLK_DIV=4 unit, indexed by tick since reset.
  logic [18:0] rec_addr [NREC];
  logic        rec_de   [NREC];
  logic        rec_hs   [NREC];
  logic        rec_vs   [NREC];
  logic        rec_vb   [NREC];
  logic        rec_fs   [NREC];
  logic [11:0] rec_rgb  [NREC];

  always @(negedge clk) begin
    if (!rst && ec > 0 && ec % CD == 0 && ec / CD - 1 < NREC) begin
      rec_addr[ec/CD-1] <= vif.fb_addr;
      rec_de[ec/CD-1]   <= vif.de;
      rec_hs[ec/CD-1]   <= vif.hs;
      rec_vs[ec/CD-1]   <= vif.vs;
      rec_vb[ec/CD-1]   <= vif.vblank;
      rec_fs[ec/CD-1]   <= vif.frame_start;
      rec_rgb[ec/CD-1]  <= {vif.r, vif.g, vif.b};
    end
  end

  int   fs_last = -1;
  int   fs_n = 0;
  int   fs_bad = 0;
  int   fs_wide = 0;
  logic fs_prev = 1'b0;

  always @(negedge clk) begin
    fs_prev <= vif.frame_start;
    if (vif.frame_start && fs_prev) fs_wide <= fs_wide + 1;
    if (rst) begin
      fs_last <= -1;
    end else if (vif.frame_start) begin
      if (fs_last >= 0) begin
        fs_n <= fs_n + 1;
        if (ec - fs_last != FT * CD) fs_bad <= fs_bad + 1;
      end
      fs_last <= ec;
    end
  end

  int bl_bad = 0;
  int bl_n = 0;
  always @(negedge clk) begin
    if (bm) begin
      bl_n <= bl_n + 1;
      if (!vif.de && {vif.r, vif.g, vif.b} != 12'h000) bl_bad <= bl_bad + 1;
      if (vif.de && {vif.r, vif.g, vif.b} != 12'hFFF) bl_bad <= bl_bad + 1;
      if (vif.vblank && vif.fb_addr != 19'd0) bl_bad <= bl_bad + 1;
    end
  end

  // CLK_DIV=2 unit: colour from the address issued one tick earlier,
  // 96 visible pixels and 480 clks between frame_start pulses.
  logic [18:0] prev_addr2 = '0;
  int   bad2 = 0;
  int   px2 = 0;
  int   run2 = 0;
  logic run2_ok = 1'b0;
  int   fs2_last = -1;
  int   fs2_n = 0;

  always @(negedge clk) begin
    if (rst || !chk2) begin
      run2_ok  <= 1'b0;
      fs2_last <= -1;
    end else if (ec > 0 && ec % 2 == 0) begin
      prev_addr2 <= vif2.fb_addr;
      if (vif2.de) begin
        px2 <= px2 + 1;
        if ({vif2.r, vif2.g, vif2.b} !=
            conv(prev_addr2 < 19'd128 ? ram[prev_addr2[6:0]] : 8'h00))
          bad2 <= bad2 + 1;
      end
      if (vif2.frame_start) begin
        if (run2_ok && run2 != 96) bad2 <= bad2 + 1;
        if (fs2_last >= 0) begin
          fs2_n <= fs2_n + 1;
          if (ec - fs2_last != FT * 2) bad2 <= bad2 + 1;
        end
        fs2_last <= ec;
        run2_ok  <= 1'b1;
        run2     <= vif2.de ? 1 : 0;
      end else if (vif2.de) begin
        run2 <= run2 + 1;
      end
    end
  end

  vec_t tbl [17];

  initial begin
    for (int a = 0; a < 128; a++) ram[a] = 8'(a);
    ram[0] = 8'hE3;
    ram[1] = 8'h1C;

    tbl[0]  = '{0,  0, 0,  1, 1, 1, 0, 'hF0F};
    tbl[1]  = '{1,  0, 1,  1, 1, 1, 0, 'h0F0};
    tbl[2]  = '{15, 0, 15, 1, 1, 1, 0, 'h06F};
    tbl[3]  = '{16, 0, 0,  0, 1, 1, 0, 0};
    tbl[4]  = '{17, 0, 0,  0, 1, 1, 0, 0};
    tbl[5]  = '{18, 0, 0,  0, 0, 1, 0, 0};
    tbl[6]  = '{20, 0, 0,  0, 0, 1, 0, 0};
    tbl[7]  = '{21, 0, 0,  0, 1, 1, 0, 0};
    tbl[8]  = '{23, 0, 0,  0, 1, 1, 0, 0};
    tbl[9]  = '{0,  1, 16, 1, 1, 1, 0, 'h090};
    tbl[10] = '{5,  3, 53, 1, 1, 1, 0, 'h2B5};
    tbl[11] = '{15, 5, 95, 1, 1, 1, 0, 'h4FF};
    tbl[12] = '{0,  6, 0,  0, 1, 1, 1, 0};
    tbl[13] = '{0,  7, 0,  0, 1, 0, 1, 0};
    tbl[14] = '{19, 8, 0,  0, 0, 0, 1, 0};
    tbl[15] = '{0,  9, 0,  0, 1, 1, 1, 0};
    tbl[16] = '{23, 9, 0,  0, 1, 1, 1, 0};

    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (150) @(posedge clk);

    #1 rst = 1'b1;
    #1;
    chk("rst_hs", int'(vif.hs), 1);
    chk("rst_vs", int'(vif.vs), 1);
    chk("rst_de", int'(vif.de), 0);
    chk("rst_rgb", int'({vif.r, vif.g, vif.b}), 0);
    chk("rst_addr", int'(vif.fb_addr), 0);
    chk("rst_fs", int'(vif.frame_start), 0);
    chk("rst2_de_rgb", int'({vif2.de, vif2.r, vif2.g, vif2.b}), 0);
    chk("rst2_sync", int'({vif2.hs, vif2.vs}), 3);
    repeat (3) @(posedge clk);
    @(negedge clk) begin
      rst  = 1'b0;
      chk2 = 1'b1;
    end

    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      chk($sformatf("fs_edge%0d", j), int'(vif.frame_start), (j == 2 * CD) ? 1 : 0);
    end

    repeat (CD * 492) @(negedge clk);

    foreach (tbl[n]) begin
      int i;
      i = FT + tbl[n].v * HT + tbl[n].h;
      chk($sformatf("addr_v%0d", n), int'(rec_addr[i]), tbl[n].addr);
      chk($sformatf("de_v%0d", n), int'(rec_de[i+1]), tbl[n].de);
      chk($sformatf("hs_v%0d", n), int'(rec_hs[i+1]), tbl[n].hs);
      chk($sformatf("vs_v%0d", n), int'(rec_vs[i+1]), tbl[n].vs);
      chk($sformatf("rgb_v%0d", n), int'(rec_rgb[i+1]), tbl[n].rgb);
      chk($sformatf("vblank_v%0d", n), int'(rec_vb[i-1]), tbl[n].vb);
      chk($sformatf("fs_v%0d", n), int'(rec_fs[i+1]), (n == 0) ? 1 : 0);
    end

    @(negedge clk) begin
      force_ff = 1'b1;
      chk2     = 1'b0;
    end
    repeat (2 * CD) @(negedge clk);
    bm = 1'b1;
    repeat (FT * CD + 40) @(negedge clk);
    bm = 1'b0;
    @(negedge clk);

    chk("fs_period_bad", fs_bad, 0);
    chk("fs_periods_seen", int'(fs_n >= 2), 1);
    chk("fs_width", fs_wide, 0);
    chk("blank_bad", bl_bad, 0);
    chk("blank_samples", int'(bl_n >= FT * CD), 1);
    chk("div2_bad", bad2, 0);
    chk("div2_frames", int'(fs2_n >= 2), 1);
    chk("div2_pixels", int'(px2 >= 3 * 96), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
